// File: rtl/serial_paralelo_sync.sv
// Serial-to-parallel converter with comma alignment, running only on the bit clock.
// Word boundaries come from an internal phase counter that is re-zeroed by the comma search.
module serial_paralelo_sync #(
    parameter int               WIDTH          = 8,
    parameter logic [WIDTH-1:0] COMMA          = WIDTH'(8'hBC),
    parameter int               LOCK_COUNT     = 4,
    parameter int               MISALIGN_LIMIT = 4
) (
    input  logic             clk_32f,
    input  logic             reset_L,
    input  logic             data_in,
    output logic [WIDTH-1:0] data_out,
    output logic             valid_out,
    output logic             active_out,
    output logic             word_strobe
);

    localparam int PW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
    localparam int CW = $clog2(LOCK_COUNT) + 1;
    localparam int EW = $clog2(MISALIGN_LIMIT) + 1;

    localparam logic [PW-1:0] PHASE_LAST = PW'(WIDTH - 1);
    localparam logic [CW-1:0] LOCK_LIM   = CW'(LOCK_COUNT);
    localparam logic [EW-1:0] ERR_LIM    = EW'(MISALIGN_LIMIT);

    typedef enum logic [1:0] {
        SEARCH = 2'd0,
        COUNT  = 2'd1,
        LOCKED = 2'd2
    } state_t;

    state_t           state;
    logic [WIDTH-2:0] sr;
    logic [WIDTH-1:0] w;
    logic [PW-1:0]    phase;
    logic [CW-1:0]    comma_cnt;
    logic [EW-1:0]    err_cnt;
    logic             boundary;
    logic             is_comma;

    // Window includes the bit sampled at this very edge.
    assign w        = {sr, data_in};
    assign is_comma = (w == COMMA);
    assign boundary = (phase == PHASE_LAST);

    always_ff @(posedge clk_32f) begin
        if (!reset_L) begin
            state       <= SEARCH;
            sr          <= '0;
            phase       <= '0;
            comma_cnt   <= '0;
            err_cnt     <= '0;
            data_out    <= '0;
            valid_out   <= 1'b0;
            active_out  <= 1'b0;
            word_strobe <= 1'b0;
        end else begin
            sr    <= w[WIDTH-2:0];
            phase <= boundary ? '0 : phase + 1'b1;

            case (state)
                SEARCH: begin
                    valid_out   <= 1'b0;
                    word_strobe <= 1'b0;
                    if (is_comma) begin
                        phase     <= '0;
                        comma_cnt <= CW'(1);
                        if (LOCK_COUNT == 1) begin
                            state      <= LOCKED;
                            active_out <= 1'b1;
                        end else begin
                            state <= COUNT;
                        end
                    end
                end

                COUNT: begin
                    valid_out   <= 1'b0;
                    word_strobe <= 1'b0;
                    if (boundary) begin
                        if (is_comma) begin
                            comma_cnt <= comma_cnt + 1'b1;
                            if (comma_cnt + 1'b1 == LOCK_LIM) begin
                                state      <= LOCKED;
                                active_out <= 1'b1;
                            end
                        end else begin
                            state     <= SEARCH;
                            comma_cnt <= '0;
                        end
                    end
                end

                LOCKED: begin
                    if (boundary) begin
                        data_out    <= w;
                        valid_out   <= !is_comma;
                        word_strobe <= 1'b1;
                        if (is_comma) begin
                            err_cnt <= '0;
                        end
                    end else begin
                        word_strobe <= 1'b0;
                        // A comma off the word grid means the lane slipped.
                        if (is_comma) begin
                            if (err_cnt + 1'b1 == ERR_LIM) begin
                                state      <= SEARCH;
                                active_out <= 1'b0;
                                valid_out  <= 1'b0;
                                err_cnt    <= '0;
                                comma_cnt  <= '0;
                            end else begin
                                err_cnt <= err_cnt + 1'b1;
                            end
                        end
                    end
                end

                default: begin
                    state <= SEARCH;
                end
            endcase
        end
    end

endmodule
